hand_register_responder: RTL and testbench

- Responder side of the round controller's card-load interface.
- Watches the six one-hot load strobes (player cards 1–3, dealer cards 1–3) and fetches a card from the card source over a req/valid handshake.
- Stores the fetched card in the addressed slot, then returns registered pscore, dscore and pcard3 to the round controller.
- Sits between the round controller and the card source; all logic is clocked on clk.

---
 rtl/hand_register_responder.sv | 145 ++++++++++++++
 tb/tb_hand_register_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hand_register_responder.sv
// Card-load responder: fetches a card over req/valid for each load strobe event,
// stores it in the addressed slot and returns registered hand scores.
// Optional macro STRICT_ORDER_EN enforces the deal order within a hand.
module hand_register_responder #(
  parameter int unsigned REQ_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  input  logic       card_valid,
  input  logic [3:0] card_in,
  output logic       card_req,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       card_done,
  output logic       proto_err,
  output logic       timeout_err
);

  localparam int unsigned NSLOT = 6;
  localparam int unsigned TW    = 8;

  typedef enum logic [1:0] {IDLE, REQ, UPDATE} state_t;

  state_t          state;
  logic [NSLOT-1:0] strb, strb_q, rise, tgt;
  logic [3:0]      slot [NSLOT];
  logic [TW-1:0]   cnt;
  logic            multi, order_ok, legal, card_ok;

  // Slot bit order: p1, p2, p3, d1, d2, d3
  assign strb    = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};
  assign rise    = strb & ~strb_q;
  assign multi   = |(rise & (rise - 6'd1));
  assign card_ok = (card_in >= 4'd1) && (card_in <= 4'd13);
  assign legal   = (rise != '0) && !multi && order_ok;

`ifdef STRICT_ORDER_EN
  // One-hot of the last captured slot in this hand; zero means only pcard1 may follow
  logic [NSLOT-1:0] last;
  assign order_ok = rise[0] | (rise[3] & last[0]) | (rise[1] & last[3]) |
                    (rise[4] & last[1]) | (rise[2] & last[4]) |
                    (rise[5] & (last[4] | last[2]));
`else
  assign order_ok = 1'b1;
`endif

  function automatic logic [3:0] card_val(input logic [3:0] c);
    return ((c >= 4'd1) && (c <= 4'd9)) ? c : 4'd0;
  endfunction

  function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] c);
    logic [4:0] s;
    s = 5'(card_val(a)) + 5'(card_val(b)) + 5'(card_val(c));
    if (s >= 5'd20)      return 4'(s - 5'd20);
    else if (s >= 5'd10) return 4'(s - 5'd10);
    else                 return 4'(s);
  endfunction

  always_ff @(posedge clk) begin
    if (resetb) begin
      state       <= IDLE;
      strb_q      <= '0;
      tgt         <= '0;
      cnt         <= '0;
      card_req    <= 1'b0;
      card_done   <= 1'b0;
      pscore      <= 4'd0;
      dscore      <= 4'd0;
      proto_err   <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < NSLOT; i++) slot[i] <= 4'd0;
`ifdef STRICT_ORDER_EN
      last        <= '0;
`endif
    end else begin
      strb_q    <= strb;
      card_done <= 1'b0;
      if ((rise != '0) && ((state != IDLE) || !legal)) proto_err <= 1'b1;
      case (state)
        IDLE: begin
          if (legal) begin
            tgt      <= rise;
            cnt      <= '0;
            card_req <= 1'b1;
            state    <= REQ;
            // pcard1 opens a new hand
            if (rise[0]) begin
              for (int i = 0; i < NSLOT; i++) slot[i] <= 4'd0;
`ifdef STRICT_ORDER_EN
              last <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (card_valid && card_ok) begin
            for (int i = 0; i < NSLOT; i++) if (tgt[i]) slot[i] <= card_in;
            card_req <= 1'b0;
            state    <= UPDATE;
`ifdef STRICT_ORDER_EN
            last     <= tgt;
`endif
          end else begin
            if (card_valid) proto_err <= 1'b1;
            if (cnt == TW'(REQ_TIMEOUT - 1)) begin
              timeout_err <= 1'b1;
              card_req    <= 1'b0;
              state       <= IDLE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        UPDATE: begin
          pscore    <= hand_score(slot[0], slot[1], slot[2]);
          dscore    <= hand_score(slot[3], slot[4], slot[5]);
          card_done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pcard1 = slot[0];
  assign pcard2 = slot[1];
  assign pcard3 = slot[2];
  assign dcard1 = slot[3];
  assign dcard2 = slot[4];
  assign dcard3 = slot[5];

endmodule

// File: tb/tb_hand_register_responder.sv
// Self-checking bench for hand_register_responder: directed scenarios plus
// randomized hands compared against a slot/score model.
module tb_hand_register_responder;

  logic       clk = 1'b0;
  logic       resetb;
  logic [5:0] ld;
  logic       card_valid;
  logic [3:0] card_in;
  logic       card_req, card_done, proto_err, timeout_err;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_slot [6];
  logic [3:0] m_ps, m_ds;
  logic       m_proto, m_tmo;

  hand_register_responder #(.REQ_TIMEOUT(255)) dut (
    .clk(clk), .resetb(resetb),
    .load_pcard1(ld[0]), .load_pcard2(ld[1]), .load_pcard3(ld[2]),
    .load_dcard1(ld[3]), .load_dcard2(ld[4]), .load_dcard3(ld[5]),
    .card_valid(card_valid), .card_in(card_in), .card_req(card_req),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .pscore(pscore), .dscore(dscore), .card_done(card_done),
    .proto_err(proto_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int val(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic logic [3:0] score(input int a, input int b, input int c);
    return 4'((val(a) + val(b) + val(c)) % 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic req_exp, input logic done_exp);
    chk({tag, ".pcard1"}, pcard1, m_slot[0]);
    chk({tag, ".pcard2"}, pcard2, m_slot[1]);
    chk({tag, ".pcard3"}, pcard3, m_slot[2]);
    chk({tag, ".dcard1"}, dcard1, m_slot[3]);
    chk({tag, ".dcard2"}, dcard2, m_slot[4]);
    chk({tag, ".dcard3"}, dcard3, m_slot[5]);
    chk({tag, ".pscore"}, pscore, m_ps);
    chk({tag, ".dscore"}, dscore, m_ds);
    chk({tag, ".proto_err"}, proto_err, m_proto);
    chk({tag, ".timeout_err"}, timeout_err, m_tmo);
    chk({tag, ".card_req"}, card_req, req_exp);
    chk({tag, ".card_done"}, card_done, done_exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_slot[i] = 4'd0;
    m_ps = 4'd0; m_ds = 4'd0; m_proto = 1'b0; m_tmo = 1'b0;
  endtask

  task automatic do_reset();
    resetb = 1'b1; ld = '0; card_valid = 1'b0; card_in = 4'd0;
    step(); step();
    resetb = 1'b0;
    model_reset();
  endtask

  // One full load: strobe edge, dly idle cycles, ninv rejected cards, then the card
  task automatic do_load(input int idx, input logic [3:0] card, input int dly,
                         input int ninv, input string tag);
    logic [3:0] bad;
    ld[idx] = 1'b1;
    step();
    ld[idx] = 1'b0;
    if (idx == 0) for (int i = 0; i < 6; i++) m_slot[i] = 4'd0;
    chk_all({tag, ".req"}, 1'b1, 1'b0);
    repeat (dly) step();
    chk({tag, ".req_wait"}, card_req, 1'b1);
    for (int k = 0; k < ninv; k++) begin
      case ($urandom_range(0, 2))
        0:       bad = 4'd0;
        1:       bad = 4'd14;
        default: bad = 4'd15;
      endcase
      card_valid = 1'b1; card_in = bad;
      step();
      m_proto = 1'b1;
      chk({tag, ".bad_proto"}, proto_err, 1'b1);
      chk({tag, ".bad_req"}, card_req, 1'b1);
    end
    card_valid = 1'b1; card_in = card;
    step();
    card_valid = 1'b0; card_in = 4'd0;
    m_slot[idx] = card;
    chk_all({tag, ".cap"}, 1'b0, 1'b0);
    step();
    m_ps = score(m_slot[0], m_slot[1], m_slot[2]);
    m_ds = score(m_slot[3], m_slot[4], m_slot[5]);
    chk_all({tag, ".upd"}, 1'b0, 1'b1);
    step();
    chk({tag, ".done_off"}, card_done, 1'b0);
  endtask

  initial begin
    ld = '0; card_valid = 1'b0; card_in = 4'd0; resetb = 1'b0;
    model_reset();

    do_reset();
    chk_all("reset", 1'b0, 1'b0);

    // Directed hand
    do_load(0, 4'd7,  3, 0, "p1");
    do_load(3, 4'd13, 3, 0, "d1");
    do_load(1, 4'd9,  3, 0, "p2");
    do_load(4, 4'd2,  3, 0, "d2");
    chk("hand.pscore", pscore, 4'd6);
    chk("hand.dscore", dscore, 4'd2);

    do_load(2, 4'd12, 2, 0, "p3");
    chk("p3.raw", pcard3, 4'd12);
    chk("p3.pscore", pscore, 4'd6);

    // Two strobes rising together
    ld[3] = 1'b1; ld[1] = 1'b1;
    step();
    m_proto = 1'b1;
    chk_all("multi", 1'b0, 1'b0);
    ld = '0;
    step();
    chk_all("multi2", 1'b0, 1'b0);

    // Illegal ranks are discarded while the request stays open
    do_reset();
    ld[0] = 1'b1;
    step();
    ld = '0;
    chk_all("bad.req", 1'b1, 1'b0);
    card_valid = 1'b1; card_in = 4'd0;
    step();
    m_proto = 1'b1;
    chk_all("bad.zero", 1'b1, 1'b0);
    card_in = 4'd14;
    step();
    chk_all("bad.14", 1'b1, 1'b0);
    card_in = 4'd5;
    step();
    card_valid = 1'b0; card_in = 4'd0;
    m_slot[0] = 4'd5;
    chk_all("bad.cap", 1'b0, 1'b0);
    step();
    m_ps = 4'd5;
    chk_all("bad.upd", 1'b0, 1'b1);

    // Timeout
    do_reset();
    ld[0] = 1'b1;
    step();
    ld = '0;
    chk_all("tmo.req", 1'b1, 1'b0);
    repeat (254) step();
    chk("tmo.pre", card_req, 1'b1);
    step();
    m_tmo = 1'b1;
    chk_all("tmo", 1'b0, 1'b0);
    step();
    chk_all("tmo.idle", 1'b0, 1'b0);
    do_load(0, 4'd4, 1, 0, "after_tmo");
    chk("after_tmo.pscore", pscore, 4'd4);

    // Reset during an open request
    ld[3] = 1'b1;
    step();
    ld = '0;
    chk("rst_mid.req", card_req, 1'b1);
    card_valid = 1'b1; card_in = 4'd3; resetb = 1'b1;
    step();
    resetb = 1'b0; card_valid = 1'b0; card_in = 4'd0;
    model_reset();
    chk_all("rst_mid", 1'b0, 1'b0);
    step();
    chk_all("rst_mid2", 1'b0, 1'b0);

`ifdef STRICT_ORDER_EN
    ld[1] = 1'b1;
    step();
    ld = '0;
    m_proto = 1'b1;
    chk_all("strict_p2", 1'b0, 1'b0);
`else
    do_load(4, 4'd6, 1, 0, "any_order");
    chk("any_order.dscore", dscore, 4'd6);
`endif

    // Randomized hands in deal order
    do_reset();
    for (int h = 0; h < 6; h++) begin
      do_load(0, 4'($urandom_range(1, 13)), $urandom_range(0, 4), $urandom_range(0, 2), "rnd.p1");
      do_load(3, 4'($urandom_range(1, 13)), $urandom_range(0, 4), $urandom_range(0, 2), "rnd.d1");
      do_load(1, 4'($urandom_range(1, 13)), $urandom_range(0, 4), $urandom_range(0, 2), "rnd.p2");
      do_load(4, 4'($urandom_range(1, 13)), $urandom_range(0, 4), $urandom_range(0, 2), "rnd.d2");
      if ($urandom_range(0, 1) == 1)
        do_load(2, 4'($urandom_range(1, 13)), $urandom_range(0, 4), $urandom_range(0, 2), "rnd.p3");
      if ($urandom_range(0, 1) == 1)
        do_load(5, 4'($urandom_range(1, 13)), $urandom_range(0, 4), $urandom_range(0, 2), "rnd.d3");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
